// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths, halt word, fetch FSM states and branch target table
package proc_pkg;

  localparam int unsigned PCW_DEFAULT       = 10;
  localparam logic [8:0]  HALT_WORD_DEFAULT = 9'h1FF;
  localparam int unsigned LUT_DEPTH         = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  // Branch targets selected by a 5-bit index; entry i holds 16*i + 8.
  localparam int unsigned LUT_TABLE [LUT_DEPTH] = '{
      8,  24,  40,  56,  72,  88, 104, 120,
    136, 152, 168, 184, 200, 216, 232, 248,
    264, 280, 296, 312, 328, 344, 360, 376,
    392, 408, 424, 440, 456, 472, 488, 504
  };

endpackage

// File: rtl/pc_lut.sv
// rtl/pc_lut.sv - FETCH_LUT_EN: combinational branch index to target table
`ifdef FETCH_LUT_EN
module pc_lut
  import proc_pkg::*;
#(
  parameter int unsigned PCW = PCW_DEFAULT
) (
  input  logic [4:0]     idx,
  output logic [PCW-1:0] target
);

  // Pure table lookup; the table is fixed at elaboration.
  always_comb begin
    target = PCW'(LUT_TABLE[idx]);
  end

endmodule
`endif

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch with output/skid buffer and replay; FETCH_LUT_EN selects table branch targets
module instr_fetch
  import proc_pkg::*;
#(
  parameter int unsigned PCW       = PCW_DEFAULT,
  parameter logic [8:0]  HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic [PCW-1:0] imem_addr,
  input  logic [8:0]     imem_rdata,
  output logic [8:0]     instr,
  output logic           instr_valid,
  input  logic           instr_ready,
  input  logic           branch_taken,
  input  logic [PCW-1:0] branch_tgt,
  output logic [PCW-1:0] pc_out,
  output logic           done
);

  localparam logic [PCW:0] PC_ONE = (PCW+1)'(1);

  fetch_state_t   state;
  // Next address to issue; the extra MSB flags that fetch ran past the top.
  logic [PCW:0]   pc;
  // Registered read address; s1_v marks it as a live read the memory samples next edge.
  logic [PCW-1:0] addr_q;
  logic           s1_v;
  // s2_v marks imem_rdata as carrying the word fetched from s2_pc.
  logic           s2_v;
  logic [PCW-1:0] s2_pc;
  logic           sk_v;
  logic [8:0]     sk_instr;
  logic [PCW-1:0] sk_pc;

  logic [PCW-1:0] tgt;
  logic [PCW:0]   tgt_inc;
  logic           redirect;
  logic           accept;
  logic           out_free;
  logic           halt_now;
  logic           replay;
  logic           issue;

`ifdef FETCH_LUT_EN
  logic [31:0] tgt_ext;
  logic        unused_tgt_hi;
  assign tgt_ext       = 32'(branch_tgt);
  assign unused_tgt_hi = ^tgt_ext[31:5];
  pc_lut #(.PCW(PCW)) u_pc_lut (
    .idx    (tgt_ext[4:0]),
    .target (tgt)
  );
`else
  assign tgt = branch_tgt;
`endif

  assign redirect = (state == ST_RUN) && branch_taken;
  assign accept   = instr_valid && instr_ready;
  assign out_free = !instr_valid || accept;
  assign halt_now = accept && ((instr == HALT_WORD) || (&pc_out));
  assign tgt_inc  = {1'b0, tgt} + PC_ONE;
  // The arriving word has nowhere to land: drop it and the younger read, refetch from it.
  assign replay   = s2_v && !out_free && sk_v;
  // Stop issuing while both buffer slots are full and nothing drains.
  assign issue    = !pc[PCW] && !(instr_valid && sk_v && !accept);

  // A branch presents its target to memory in the same cycle so only one bubble follows.
  assign imem_addr = redirect ? tgt : addr_q;

  // Fetch FSM, read pipeline, output register and skid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      addr_q      <= '0;
      s1_v        <= 1'b0;
      s2_v        <= 1'b0;
      s2_pc       <= '0;
      sk_v        <= 1'b0;
      sk_instr    <= '0;
      sk_pc       <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state       <= ST_RUN;
            done        <= 1'b0;
            addr_q      <= '0;
            pc          <= PC_ONE;
            s1_v        <= 1'b1;
            s2_v        <= 1'b0;
            sk_v        <= 1'b0;
            instr_valid <= 1'b0;
          end
        end
        ST_RUN: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            sk_v        <= 1'b0;
            s2_v        <= 1'b1;
            s2_pc       <= tgt;
            if (tgt_inc[PCW]) begin
              s1_v <= 1'b0;
              pc   <= tgt_inc;
            end else begin
              addr_q <= tgt_inc[PCW-1:0];
              s1_v   <= 1'b1;
              pc     <= tgt_inc + PC_ONE;
            end
          end else if (halt_now) begin
            state       <= ST_HALT;
            done        <= 1'b1;
            instr_valid <= 1'b0;
            sk_v        <= 1'b0;
            s1_v        <= 1'b0;
            s2_v        <= 1'b0;
          end else begin
            if (out_free) begin
              if (sk_v) begin
                instr       <= sk_instr;
                pc_out      <= sk_pc;
                instr_valid <= 1'b1;
                if (s2_v) begin
                  sk_instr <= imem_rdata;
                  sk_pc    <= s2_pc;
                end else begin
                  sk_v <= 1'b0;
                end
              end else if (s2_v) begin
                instr       <= imem_rdata;
                pc_out      <= s2_pc;
                instr_valid <= 1'b1;
              end else begin
                instr_valid <= 1'b0;
              end
            end else if (s2_v && !sk_v) begin
              sk_v     <= 1'b1;
              sk_instr <= imem_rdata;
              sk_pc    <= s2_pc;
            end
            if (replay) begin
              addr_q <= s2_pc;
              s1_v   <= 1'b1;
              s2_v   <= 1'b0;
              pc     <= {1'b0, s2_pc} + PC_ONE;
            end else begin
              s2_v  <= s1_v;
              s2_pc <= addr_q;
              if (issue) begin
                addr_q <= pc[PCW-1:0];
                s1_v   <= 1'b1;
                pc     <= pc + PC_ONE;
              end else begin
                s1_v <= 1'b0;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] imem_addr;
  logic [8:0] imem_rdata;
  logic [8:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       branch_taken;
  logic [9:0] branch_tgt;
  logic [9:0] pc_out;
  logic       done;

  logic       start4;
  logic [3:0] imem_addr4;
  logic [8:0] imem_rdata4;
  logic [8:0] instr4;
  logic       instr_valid4;
  logic       instr_ready4;
  logic       branch_taken4;
  logic [3:0] branch_tgt4;
  logic [3:0] pc_out4;
  logic       done4;

  logic [8:0] rom  [1024];
  logic [8:0] rom4 [16];

  int n_assert = 0;
  int n_fail   = 0;

`ifdef FETCH_LUT_EN
  localparam logic [9:0] TGT_DRV  = 10'd3;
  localparam logic [9:0] EXP_TGT  = 10'd56;
  localparam logic [8:0] EXP_DATA = 9'h038;
`else
  localparam logic [9:0] TGT_DRV  = 10'd40;
  localparam logic [9:0] EXP_TGT  = 10'd40;
  localparam logic [8:0] EXP_DATA = 9'h028;
`endif

  instr_fetch u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .branch_tgt   (branch_tgt),
    .pc_out       (pc_out),
    .done         (done)
  );

  instr_fetch #(.PCW(4)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .start        (start4),
    .imem_addr    (imem_addr4),
    .imem_rdata   (imem_rdata4),
    .instr        (instr4),
    .instr_valid  (instr_valid4),
    .instr_ready  (instr_ready4),
    .branch_taken (branch_taken4),
    .branch_tgt   (branch_tgt4),
    .pc_out       (pc_out4),
    .done         (done4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata  <= rom[imem_addr];
    imem_rdata4 <= rom4[imem_addr4];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'(i & 255);
    for (int i = 0; i < 6; i++) rom[i] = 9'(i + 1);
    rom[6] = 9'h1FF;
    for (int i = 0; i < 16; i++) rom4[i] = 9'(9'h040 + i);

    reset = 1'b1; start = 1'b0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_tgt = '0;
    start4 = 1'b0; instr_ready4 = 1'b0; branch_taken4 = 1'b0; branch_tgt4 = '0;
    step(); step();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_done",  32'(done),        32'd0);
    check("rst_instr", 32'(instr),       32'd0);
    check("rst_pc",    32'(pc_out),      32'd0);
    check("rst_addr",  32'(imem_addr),   32'd0);
    reset = 1'b0;
    step();

    // Straight-line run to the halt word at address 6.
    instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("s0_valid", 32'(instr_valid), 32'd0);
    step();
    check("s1_valid", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("run_valid", 32'(instr_valid), 32'd1);
      check("run_instr", 32'(instr),       32'(k + 1));
      check("run_pc",    32'(pc_out),      32'(k));
    end
    step();
    check("halt_instr", 32'(instr),       32'h1FF);
    check("halt_pc",    32'(pc_out),      32'd6);
    check("halt_valid", 32'(instr_valid), 32'd1);
    step();
    check("done_rise",  32'(done),        32'd1);
    check("done_valid", 32'(instr_valid), 32'd0);
    step();
    check("done_hold",  32'(done),        32'd1);

    // Restart from HALT, stall on 003, then branch while stalled with skid full.
    start = 1'b1;
    step();
    start = 1'b0;
    check("rs_done", 32'(done), 32'd0);
    step();
    step();
    check("rs_valid", 32'(instr_valid), 32'd1);
    check("rs_pc",    32'(pc_out),      32'd0);
    check("rs_instr", 32'(instr),       32'h001);
    step();
    check("rs_instr1", 32'(instr), 32'h002);
    step();
    check("rs_instr2", 32'(instr), 32'h003);
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", 32'(instr),       32'h003);
      check("stall_pc",    32'(pc_out),      32'd2);
    end
    instr_ready = 1'b1;
    step();
    check("rel_instr", 32'(instr),  32'h004);
    check("rel_pc",    32'(pc_out), 32'd3);
    instr_ready = 1'b0;
    step();
    check("st2_instr", 32'(instr),       32'h004);
    check("st2_valid", 32'(instr_valid), 32'd1);
    branch_taken = 1'b1;
    branch_tgt   = TGT_DRV;
    step();
    branch_taken = 1'b0;
    branch_tgt   = '0;
    check("br_bubble", 32'(instr_valid), 32'd0);
    step();
    check("br_valid", 32'(instr_valid), 32'd1);
    check("br_pc",    32'(pc_out),      32'(EXP_TGT));
    check("br_instr", 32'(instr),       32'(EXP_DATA));
    instr_ready = 1'b1;
    step();
    check("br_pc1",    32'(pc_out), 32'(EXP_TGT + 10'd1));
    check("br_instr1", 32'(instr),  32'(EXP_DATA + 9'd1));

    // Asynchronous reset in the middle of a stream.
    step();
    #3;
    reset = 1'b1;
    #1;
    check("ar_valid", 32'(instr_valid), 32'd0);
    check("ar_instr", 32'(instr),       32'd0);
    check("ar_pc",    32'(pc_out),      32'd0);
    check("ar_addr",  32'(imem_addr),   32'd0);
    check("ar_done",  32'(done),        32'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ar_idle", 32'(instr_valid), 32'd0);
    end

    // PCW=4: run off the top of the address space.
    instr_ready4 = 1'b1;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      check("p4_valid", 32'(instr_valid4), 32'd1);
      check("p4_pc",    32'(pc_out4),      32'(i));
      check("p4_instr", 32'(instr4),       32'(9'h040 + i));
    end
    step();
    check("p4_done",  32'(done4),        32'd1);
    check("p4_valid", 32'(instr_valid4), 32'd0);
    check("p4_addr",  32'(imem_addr4),   32'hF);
    step();
    check("p4_done2", 32'(done4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
